// File: rtl/rgmii_rx_delay_cal_if.sv
// Signal bundle between the RGMII RX delay calibrator and its surroundings:
// run control, observed GMII receive bus, IDELAY controls and results.
interface rgmii_rx_delay_cal_if;
  // start is a single-cycle request; a run acknowledges it by raising busy on
  // the following cycle, and done stays high from run end until the next start.
  logic       start;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic       idelay_load;
  logic [8:0] idelay_cnt_value_in;
  logic       idelay_en_vtc;
  logic       busy;
  logic       done;
  logic       fail;
  logic [8:0] window_lo;
  logic [8:0] window_hi;
  logic [8:0] tap_sel;
  logic [3:0] dbg_state;

  modport master (
    output start, gmii_rxd, gmii_rx_dv, gmii_rx_er,
    input  idelay_load, idelay_cnt_value_in, idelay_en_vtc,
    input  busy, done, fail, window_lo, window_hi, tap_sel, dbg_state
  );

  modport slave (
    input  start, gmii_rxd, gmii_rx_dv, gmii_rx_er,
    output idelay_load, idelay_cnt_value_in, idelay_en_vtc,
    output busy, done, fail, window_lo, window_hi, tap_sel, dbg_state
  );
endinterface

// File: rtl/rgmii_rx_delay_cal.sv
// Sweeps the shared RGMII RX IDELAY tap, qualifies each tap by counting clean
// preambles, and loads the centre of the longest contiguous passing window.
module rgmii_rx_delay_cal #(
  parameter int MAX_TAP       = 511,
  parameter int TAP_STEP      = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int OBS_CYCLES    = 1048576,
  parameter int MIN_GOOD      = 4,
  parameter int DEFAULT_TAP   = 0
) (
  input  logic               clk,
  input  logic               rst,
  rgmii_rx_delay_cal_if.slave bus
);

  localparam int WAIT_W = $clog2(SETTLE_CYCLES > 8 ? SETTLE_CYCLES : 8);
  localparam int OBS_W  = (OBS_CYCLES > 1) ? $clog2(OBS_CYCLES) : 1;
  localparam int GOOD_W = $clog2(MIN_GOOD + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_VTC_OFF, S_LOAD, S_SETTLE, S_OBSERVE,
    S_EVAL, S_FINAL_LOAD, S_FINAL_SETTLE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [OBS_W-1:0]    obs_q, obs_d;
  logic [8:0]          tap_q, tap_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic                bad_q, bad_d;
  logic                chk_q, chk_d;
  logic [1:0]          pre_q, pre_d;
  logic                er_q, er_d;
  logic                dv_prev_q;
  logic                run_open_q, run_open_d;
  logic [8:0]          run_lo_q, run_lo_d, run_hi_q, run_hi_d;
  logic [9:0]          run_len_q, run_len_d;
  logic [8:0]          best_lo_q, best_lo_d, best_hi_q, best_hi_d;
  logic [9:0]          best_len_q, best_len_d;
  logic [8:0]          cnt_val_q, cnt_val_d;
  logic                done_q, done_d, fail_q, fail_d;
  logic [8:0]          win_lo_q, win_lo_d, win_hi_q, win_hi_d;
  logic [8:0]          tap_sel_q, tap_sel_d;

  logic                frame_edge, good_now, bad_now, pass, last;
  logic [1:0]          pre_cur;
  logic                er_cur;
  logic [9:0]          centre_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      obs_q      <= '0;
      tap_q      <= '0;
      good_q     <= '0;
      bad_q      <= 1'b0;
      chk_q      <= 1'b0;
      pre_q      <= '0;
      er_q       <= 1'b0;
      dv_prev_q  <= 1'b0;
      run_open_q <= 1'b0;
      run_lo_q   <= '0;
      run_hi_q   <= '0;
      run_len_q  <= '0;
      best_lo_q  <= '0;
      best_hi_q  <= '0;
      best_len_q <= '0;
      cnt_val_q  <= '0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      win_lo_q   <= '0;
      win_hi_q   <= '0;
      tap_sel_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      obs_q      <= obs_d;
      tap_q      <= tap_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      chk_q      <= chk_d;
      pre_q      <= pre_d;
      er_q       <= er_d;
      dv_prev_q  <= bus.gmii_rx_dv;
      run_open_q <= run_open_d;
      run_lo_q   <= run_lo_d;
      run_hi_q   <= run_hi_d;
      run_len_q  <= run_len_d;
      best_lo_q  <= best_lo_d;
      best_hi_q  <= best_hi_d;
      best_len_q <= best_len_d;
      cnt_val_q  <= cnt_val_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      win_lo_q   <= win_lo_d;
      win_hi_q   <= win_hi_d;
      tap_sel_q  <= tap_sel_d;
    end
  end

  // A check in flight always has dv_prev high, so it never coincides with a new edge.
  assign frame_edge = bus.gmii_rx_dv & ~dv_prev_q;
  assign pre_cur    = frame_edge ? 2'd0 : pre_q;
  assign er_cur     = frame_edge ? 1'b0 : er_q;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    obs_d      = obs_q;
    tap_d      = tap_q;
    good_d     = good_q;
    bad_d      = bad_q;
    chk_d      = chk_q;
    pre_d      = pre_q;
    er_d       = er_q;
    run_open_d = run_open_q;
    run_lo_d   = run_lo_q;
    run_hi_d   = run_hi_q;
    run_len_d  = run_len_q;
    best_lo_d  = best_lo_q;
    best_hi_d  = best_hi_q;
    best_len_d = best_len_q;
    cnt_val_d  = cnt_val_q;
    done_d     = done_q;
    fail_d     = fail_q;
    win_lo_d   = win_lo_q;
    win_hi_d   = win_hi_q;
    tap_sel_d  = tap_sel_q;
    good_now   = 1'b0;
    bad_now    = 1'b0;
    pass       = 1'b0;
    last       = 1'b0;
    centre_sum = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_VTC_OFF;
          done_d     = 1'b0;
          fail_d     = 1'b0;
          tap_d      = '0;
          wait_d     = '0;
          run_open_d = 1'b0;
          run_lo_d   = '0;
          run_hi_d   = '0;
          run_len_d  = '0;
          best_lo_d  = '0;
          best_hi_d  = '0;
          best_len_d = '0;
        end
      end
      S_VTC_OFF: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == WAIT_W'(7)) begin
          state_d   = S_LOAD;
          cnt_val_d = tap_q;
          wait_d    = '0;
        end
      end
      S_LOAD: begin
        state_d = S_SETTLE;
        wait_d  = '0;
      end
      S_SETTLE: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == WAIT_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_OBSERVE;
          good_d  = '0;
          bad_d   = 1'b0;
          chk_d   = 1'b0;
          obs_d   = '0;
        end
      end
      S_OBSERVE: begin
        obs_d = obs_q + 1'b1;
        if (chk_q || frame_edge) begin
          if (!bus.gmii_rx_dv) begin
            bad_now = 1'b1;
            chk_d   = 1'b0;
          end else if (bus.gmii_rxd == 8'h55) begin
            chk_d = 1'b1;
            pre_d = (pre_cur == 2'd2) ? 2'd2 : pre_cur + 2'd1;
            er_d  = er_cur | bus.gmii_rx_er;
          end else begin
            chk_d = 1'b0;
            if (bus.gmii_rxd == 8'hD5 && pre_cur == 2'd2 && !er_cur && !bus.gmii_rx_er)
              good_now = 1'b1;
            else
              bad_now = 1'b1;
          end
        end
        if (good_now) good_d = good_q + 1'b1;
        if (bad_now)  bad_d  = 1'b1;
        if (bad_now || (good_now && good_q == GOOD_W'(MIN_GOOD - 1)) ||
            obs_q == OBS_W'(OBS_CYCLES - 1))
          state_d = S_EVAL;
      end
      S_EVAL: begin
        pass = (good_q >= GOOD_W'(MIN_GOOD)) && !bad_q;
        last = ({1'b0, tap_q} + 10'(TAP_STEP)) > 10'(MAX_TAP);
        if (pass) begin
          if (!run_open_q) begin
            run_lo_d  = tap_q;
            run_len_d = 10'd1;
          end else begin
            run_len_d = run_len_q + 10'd1;
          end
          run_hi_d   = tap_q;
          run_open_d = 1'b1;
        end
        // Strictly-greater replacement keeps the earliest of equal-length windows.
        if ((!pass || last) && run_open_d) begin
          if (run_len_d > best_len_q) begin
            best_lo_d  = run_lo_d;
            best_hi_d  = run_hi_d;
            best_len_d = run_len_d;
          end
          run_open_d = 1'b0;
          run_len_d  = '0;
        end
        if (last) begin
          state_d = S_FINAL_LOAD;
          if (best_len_d != '0) begin
            centre_sum = {1'b0, best_lo_d} + {1'b0, best_hi_d};
            tap_sel_d  = centre_sum[9:1];
            win_lo_d   = best_lo_d;
            win_hi_d   = best_hi_d;
            fail_d     = 1'b0;
          end else begin
            tap_sel_d = 9'(DEFAULT_TAP);
            win_lo_d  = '0;
            win_hi_d  = '0;
            fail_d    = 1'b1;
          end
          cnt_val_d = tap_sel_d;
        end else begin
          tap_d     = tap_q + 9'(TAP_STEP);
          cnt_val_d = tap_d;
          state_d   = S_LOAD;
        end
      end
      S_FINAL_LOAD: begin
        state_d = S_FINAL_SETTLE;
        wait_d  = '0;
      end
      S_FINAL_SETTLE: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == WAIT_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Load strobes only exist in states where VT compensation is already off.
  assign bus.idelay_load         = (state_q == S_LOAD) || (state_q == S_FINAL_LOAD);
  assign bus.idelay_cnt_value_in = cnt_val_q;
  assign bus.idelay_en_vtc       = (state_q == S_IDLE) || (state_q == S_DONE);
  assign bus.busy                = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done                = done_q;
  assign bus.fail                = fail_q;
  assign bus.window_lo           = win_lo_q;
  assign bus.window_hi           = win_hi_q;
  assign bus.tap_sel             = tap_sel_q;
  assign bus.dbg_state           = state_q;

endmodule

// File: tb/tb_rgmii_rx_delay_cal.sv
// Bench for rgmii_rx_delay_cal: a PHY model emits preamble frames whose quality
// depends on the loaded tap; results are checked against a window-search model.
module tb_rgmii_rx_delay_cal;

  localparam int MAX_TAP     = 255;
  localparam int TAP_STEP    = 8;
  localparam int SETTLE      = 16;
  localparam int OBS_CYCLES  = 256;
  localparam int MIN_GOOD    = 4;
  localparam int DEFAULT_TAP = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rgmii_rx_delay_cal_if bus();

  rgmii_rx_delay_cal #(
    .MAX_TAP(MAX_TAP), .TAP_STEP(TAP_STEP), .SETTLE_CYCLES(SETTLE),
    .OBS_CYCLES(OBS_CYCLES), .MIN_GOOD(MIN_GOOD), .DEFAULT_TAP(DEFAULT_TAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] exp_q[$];
  bit         pass_mask[0:511];
  bit         traffic_en = 1'b0;
  int         bad_mode = 0;   // 0 mixed faults, 1 bad SFD only, 2 rx_er pulse only
  logic [8:0] phy_tap;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // PHY model: the delay it applies is whatever was last loaded.
  always @(posedge clk or posedge rst)
    if (rst) phy_tap <= '0;
    else if (bus.idelay_load) phy_tap <= bus.idelay_cnt_value_in;

  task automatic drive_byte(input logic dv, input logic [7:0] d, input logic er);
    bus.gmii_rx_dv = dv;
    bus.gmii_rxd   = d;
    bus.gmii_rx_er = er;
    @(negedge clk);
  endtask

  task automatic send_frame(input bit good);
    int plen;
    int m;
    int er_at;
    plen = $urandom_range(2, 7);
    if (good) begin
      repeat (plen) drive_byte(1'b1, 8'h55, 1'b0);
      drive_byte(1'b1, 8'hD5, 1'b0);
      repeat ($urandom_range(1, 4)) drive_byte(1'b1, 8'($urandom), 1'b0);
    end else begin
      m = (bad_mode == 1) ? 0 : (bad_mode == 2) ? 1 : $urandom_range(0, 3);
      case (m)
        0: begin
          repeat (7) drive_byte(1'b1, 8'h55, 1'b0);
          drive_byte(1'b1, 8'hD4, 1'b0);
          repeat (2) drive_byte(1'b1, 8'($urandom), 1'b0);
        end
        1: begin
          er_at = $urandom_range(0, plen - 1);
          for (int i = 0; i < plen; i++) drive_byte(1'b1, 8'h55, (i == er_at));
          drive_byte(1'b1, 8'hD5, 1'b0);
          repeat (2) drive_byte(1'b1, 8'($urandom), 1'b0);
        end
        2: begin
          drive_byte(1'b1, 8'h55, 1'b0);
          drive_byte(1'b1, 8'hD5, 1'b0);
          drive_byte(1'b1, 8'($urandom), 1'b0);
        end
        default: repeat (3) drive_byte(1'b1, 8'h55, 1'b0);
      endcase
    end
  endtask

  initial begin
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rxd   = 8'h00;
    bus.gmii_rx_er = 1'b0;
    @(negedge clk);
    forever begin
      if (!traffic_en) begin
        drive_byte(1'b0, 8'h00, 1'b0);
      end else begin
        repeat ($urandom_range(2, 5)) drive_byte(1'b0, 8'($urandom), 1'b0);
        send_frame(pass_mask[phy_tap]);
      end
    end
  end

  // scoreboard: every load strobe must match the next expected tap, with VTC off
  always @(negedge clk) begin
    if (!rst && bus.idelay_load) begin
      check_val("load_vtc_off", bus.idelay_en_vtc, 0);
      check_val("load_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check_val("load_value", bus.idelay_cnt_value_in, exp_q.pop_front());
    end
  end

  task automatic clear_mask();
    for (int t = 0; t < 512; t++) pass_mask[t] = 1'b0;
  endtask

  task automatic set_window(input int lo, input int hi);
    for (int t = lo; t <= hi; t++) pass_mask[t] = 1'b1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Reference: walk the swept taps, find the longest passing stretch (first wins ties).
  task automatic run_cal(input string name, input bit second_start);
    int cur_lo, cur_len, best_lo, best_hi, best_len, sel, last_t, cyc;
    exp_q.delete();
    cur_lo = 0; cur_len = 0; best_lo = 0; best_hi = 0; best_len = 0; last_t = 0;
    for (int t = 0; t <= MAX_TAP; t += TAP_STEP) begin
      exp_q.push_back(9'(t));
      if (pass_mask[t]) begin
        if (cur_len == 0) cur_lo = t;
        cur_len++;
      end else begin
        if (cur_len > best_len) begin
          best_len = cur_len; best_lo = cur_lo; best_hi = last_t;
        end
        cur_len = 0;
      end
      last_t = t;
    end
    if (cur_len > best_len) begin
      best_len = cur_len; best_lo = cur_lo; best_hi = last_t;
    end
    sel = (best_len > 0) ? (best_lo + best_hi) / 2 : DEFAULT_TAP;
    if (best_len == 0) begin best_lo = 0; best_hi = 0; end
    exp_q.push_back(9'(sel));

    pulse_start();
    check_val({name, "_busy"}, bus.busy, 1);
    check_val({name, "_done_clr"}, bus.done, 0);
    check_val({name, "_vtc_off"}, bus.idelay_en_vtc, 0);
    if (second_start) begin
      repeat (300) @(negedge clk);
      pulse_start();
    end
    cyc = 0;
    while (!bus.done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check_val({name, "_done"}, bus.done, 1);
    check_val({name, "_busy_end"}, bus.busy, 0);
    check_val({name, "_vtc_on"}, bus.idelay_en_vtc, 1);
    check_val({name, "_fail"}, bus.fail, (best_len == 0));
    check_val({name, "_win_lo"}, bus.window_lo, best_lo);
    check_val({name, "_win_hi"}, bus.window_hi, best_hi);
    check_val({name, "_tap_sel"}, bus.tap_sel, sel);
    check_val({name, "_loads_left"}, exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check_val({name, "_done_hold"}, bus.done, 1);
    check_val({name, "_sel_hold"}, bus.tap_sel, sel);
  endtask

  initial begin
    int cyc;
    int a;
    bus.start = 1'b0;
    clear_mask();
    repeat (3) @(negedge clk);
    check_val("rst_load", bus.idelay_load, 0);
    check_val("rst_cnt", bus.idelay_cnt_value_in, 0);
    check_val("rst_vtc", bus.idelay_en_vtc, 1);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.done, 0);
    check_val("rst_fail", bus.fail, 0);
    check_val("rst_lo", bus.window_lo, 0);
    check_val("rst_hi", bus.window_hi, 0);
    check_val("rst_sel", bus.tap_sel, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    traffic_en = 1'b1;
    bad_mode   = 0;
    set_window(64, 128);
    run_cal("single", 1'b1);

    clear_mask(); set_window(16, 32); set_window(96, 160);
    run_cal("longest", 1'b0);

    clear_mask(); set_window(0, 16); set_window(200, 216);
    run_cal("tie", 1'b0);

    clear_mask(); bad_mode = 1;
    run_cal("none_pass", 1'b0);

    clear_mask(); set_window(64, 128); bad_mode = 2;
    run_cal("rx_er", 1'b0);

    traffic_en = 1'b0; clear_mask();
    run_cal("no_traffic", 1'b0);

    traffic_en = 1'b1; bad_mode = 0;
    for (int r = 0; r < 3; r++) begin
      clear_mask();
      a = $urandom_range(0, 31);
      set_window(a * TAP_STEP, (a + $urandom_range(0, 7)) * TAP_STEP);
      a = $urandom_range(0, 31);
      set_window(a * TAP_STEP, (a + $urandom_range(0, 7)) * TAP_STEP);
      run_cal($sformatf("rand%0d", r), 1'b0);
    end

    // abort a run while observing tap 40
    traffic_en = 1'b0; clear_mask();
    exp_q.delete();
    for (int t = 0; t <= 40; t += TAP_STEP) exp_q.push_back(9'(t));
    pulse_start();
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check_val("abort_reached_40", exp_q.size(), 0);
    repeat (SETTLE + 10) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("abort_busy", bus.busy, 0);
    check_val("abort_vtc", bus.idelay_en_vtc, 1);
    check_val("abort_load", bus.idelay_load, 0);
    check_val("abort_done", bus.done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check_val("abort_idle", bus.busy, 0);

    traffic_en = 1'b1; bad_mode = 0;
    clear_mask(); set_window(64, 128);
    run_cal("resweep", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
